// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo block and its read-side controller.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_DEPTH      = 16;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready output buffer. Entry 0 (head) drives the stream;
// entry 1 (tail) holds the word that arrived while the head was stalled.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;

  // Next-state: the head only changes on a pop or when filling an empty buffer,
  // so the stream payload stays stable while stalled.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_data;
        end else begin
          head_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage and fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign count     = cnt_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the flagless fifo: tracks occupancy by snooping the
// writer, issues reads only when data is present, and hides the one-cycle read
// latency behind a 2-entry output buffer feeding a valid/ready stream.
// Optional build macro: FIFO_RD_CTRL_ERR_EN enables the sticky ovf_err flop;
// without it ovf_err is tied low.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en_snoop,
  output logic                        fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
  output logic                        m_valid,
  output logic [DATA_WIDTH-1:0]       m_data,
  input  logic                        m_ready,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        ovf_err
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          inflight_q;
  logic [1:0]    buf_cnt;
  logic          pop;
  logic          wr_counted;

  assign pop        = m_valid & m_ready;
  assign wr_counted = wr_en_snoop & ~full_q;

  // Read issue: data must be present, and the buffer plus the read in flight,
  // less the word leaving this cycle, must leave room for one more.
  always_comb begin
    fifo_rd_en = (count_q != '0) &&
                 (({1'b0, buf_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    count_d    = count_q + CW'(wr_counted) - CW'(fifo_rd_en);
  end

  // Occupancy, registered flags and read-latency tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      inflight_q <= fifo_rd_en;
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

`ifdef FIFO_RD_CTRL_ERR_EN
  logic ovf_q;

  // Sticky flag: a write landed on a full fifo with no read to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      ovf_q <= 1'b0;
    else if (wr_en_snoop && full_q && !fifo_rd_en)   ovf_q <= 1'b1;
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_data(fifo_rd_data),
    .pop      (pop),
    .out_valid(m_valid),
    .out_data (m_data),
    .count    (buf_cnt)
  );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a behavioural fifo memory plus a word-level
// reference model (occupancy, buffered words, expected output order).
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = cnt_width(DEPTH);
  localparam int AW    = $clog2(DEPTH);
`ifdef FIFO_RD_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en_snoop = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          fifo_rd_en, m_valid, full, empty, ovf_err;
  logic [DW-1:0] fifo_rd_data, m_data;
  logic [CW-1:0] count;

  int checks = 0;
  int failures = 0;

  // reference model state
  int            m_count, m_buf, m_infl, cyc;
  bit            m_ovf;
  logic [DW-1:0] m_q[$];
  bit            e_valid, e_pop, e_rd;
  logic [DW-1:0] e_data;
  bit            cur_wr;
  logic [DW-1:0] cur_d;
  logic [DW-1:0] got_q[$];
  int            got_cyc[$];

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_snoop (wr_en_snoop),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .ovf_err     (ovf_err)
  );

  // attached fifo: bare strobes, registered read
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      fifo_rd_data <= '0;
    end else begin
      if (wr_en_snoop) begin
        mem[wp] <= wr_data;
        wp <= wp + 1'b1;
      end
      if (fifo_rd_en) begin
        fifo_rd_data <= mem[rp];
        rp <= rp + 1'b1;
      end
    end
  end

  task automatic model_clear();
    m_count = 0; m_buf = 0; m_infl = 0; m_ovf = 1'b0;
    m_q.delete();
    e_valid = 1'b0; e_pop = 1'b0; e_rd = 1'b0; e_data = '0;
  endtask

  // Apply one cycle of inputs and evaluate the model's expectations for it.
  task automatic drive(input bit wr, input logic [DW-1:0] d, input bit rdy);
    @(negedge clk);
    wr_en_snoop = wr; wr_data = d; m_ready = rdy;
    cur_wr = wr; cur_d = d;
    #1;
    e_valid = (m_buf > 0);
    e_pop   = e_valid && rdy;
    e_rd    = (m_count > 0) && (m_buf + m_infl - int'(e_pop) < 2);
    e_data  = e_valid ? m_q[0] : '0;
    if (m_valid === 1'b1 && m_ready) begin
      got_q.push_back(m_data);
      got_cyc.push_back(cyc);
      $display("xfer cyc=%0d data=%h count=%0d", cyc, m_data, count);
    end
  endtask

  // Advance the model across the clock edge.
  task automatic advance();
    bit wr_c;
    wr_c = cur_wr && (m_count != DEPTH);
    if (cur_wr && m_count == DEPTH && !e_rd) m_ovf = 1'b1;
    if (e_pop) void'(m_q.pop_front());
    if (wr_c) m_q.push_back(cur_d);
    m_buf   = m_buf - int'(e_pop) + m_infl;
    m_infl  = int'(e_rd);
    m_count = m_count + int'(wr_c) - int'(e_rd);
    cyc++;
    @(posedge clk);
  endtask

  task automatic test_reset();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL por_rd_en: got %b expected 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL por_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL por_m_data: got %h expected 0", m_data); end
    checks++; if (count !== '0) begin failures++; $display("FAIL por_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL por_flags: got empty=%b full=%b expected 1/0", empty, full); end
    checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL por_ovf: got %b expected 0", ovf_err); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin drive(1'b1, 32'h5000_0000 + i, 1'b0); advance(); end
    // reset mid-stream with words queued and buffered
    @(negedge clk);
    rst_n = 1'b0; wr_en_snoop = 1'b0; m_ready = 1'b0;
    model_clear();
    #1;
    checks++; if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_ctl: got rd_en=%b m_valid=%b expected 0/0", fifo_rd_en, m_valid); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL mid_rst_data: got %h expected 0", m_data); end
    checks++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL mid_rst_count: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (count !== '0 || m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin failures++; $display("FAIL post_rst: got count=%0d m_valid=%b rd_en=%b expected 0/0/0", count, m_valid, fifo_rd_en); end
      advance();
    end
  endtask

  task automatic test_single_word();
    drive(1'b1, 32'hA5A5_0001, 1'b1);
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL single_c0_rd: got %b expected 0", fifo_rd_en); end
    advance();
    drive(1'b0, '0, 1'b1);
    checks++; if (fifo_rd_en !== 1'b1 || count !== CW'(1)) begin failures++; $display("FAIL single_c1: got rd_en=%b count=%0d expected 1/1", fifo_rd_en, count); end
    advance();
    drive(1'b0, '0, 1'b1);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_c2_valid: got %b expected 0", m_valid); end
    advance();
    drive(1'b0, '0, 1'b1);
    checks++; if (m_valid !== 1'b1 || m_data !== 32'hA5A5_0001) begin failures++; $display("FAIL single_c3: got valid=%b data=%h expected 1/a5a50001", m_valid, m_data); end
    advance();
    drive(1'b0, '0, 1'b1);
    checks++; if (empty !== 1'b1 || m_valid !== 1'b0) begin failures++; $display("FAIL single_after: got empty=%b valid=%b expected 1/0", empty, m_valid); end
    advance();
  endtask

  task automatic test_streaming();
    int peak;
    peak = 0;
    got_q.delete(); got_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(i), 1'b1);
      if (int'(count) > peak) peak = int'(count);
      checks++; if (fifo_rd_en !== e_rd) begin failures++; $display("FAIL stream_rd_en: got %b expected %b", fifo_rd_en, e_rd); end
      advance();
    end
    for (int k = 0; k < 10 && got_q.size() < 16; k++) begin drive(1'b0, '0, 1'b1); advance(); end
    checks++; if (peak > 3) begin failures++; $display("FAIL stream_peak_count: got %0d expected <=3", peak); end
    checks++;
    if (got_q.size() != 16) begin
      failures++; $display("FAIL stream_words: got %0d expected 16", got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (got_q[i] !== DW'(i)) begin failures++; $display("FAIL stream_order[%0d]: got %h expected %h", i, got_q[i], DW'(i)); end
      end
      checks++; if (got_cyc[15] - got_cyc[0] != 15) begin failures++; $display("FAIL stream_bubbles: got span %0d expected 15", got_cyc[15] - got_cyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    int reads;
    reads = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(i), 1'b0);
      if (fifo_rd_en === 1'b1) reads++;
      if (m_valid === 1'b1) begin
        checks++; if (m_data !== '0) begin failures++; $display("FAIL bp_stable: got %h expected 0", m_data); end
      end
      advance();
    end
    drive(1'b0, '0, 1'b0);
    if (fifo_rd_en === 1'b1) reads++;
    checks++; if (reads != 2) begin failures++; $display("FAIL bp_reads: got %0d expected 2", reads); end
    checks++; if (count !== CW'(DEPTH - 2) || full !== 1'b0) begin failures++; $display("FAIL bp_count: got count=%0d full=%b expected %0d/0", count, full, DEPTH - 2); end
    checks++; if (m_valid !== 1'b1 || m_data !== '0) begin failures++; $display("FAIL bp_head: got valid=%b data=%h expected 1/0", m_valid, m_data); end
    advance();
    for (int i = 16; i < 18; i++) begin drive(1'b1, DW'(i), 1'b0); advance(); end
    drive(1'b0, '0, 1'b0);
    checks++; if (full !== 1'b1 || count !== CW'(DEPTH)) begin failures++; $display("FAIL bp_full: got full=%b count=%0d expected 1/%0d", full, count, DEPTH); end
    advance();
    got_q.delete(); got_cyc.delete();
    for (int k = 0; k < 60 && got_q.size() < 18; k++) begin drive(1'b0, '0, 1'b1); advance(); end
    checks++;
    if (got_q.size() != 18) begin
      failures++; $display("FAIL bp_drain_words: got %0d expected 18", got_q.size());
    end else begin
      for (int i = 0; i < 18; i++) begin
        checks++; if (got_q[i] !== DW'(i)) begin failures++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got_q[i], DW'(i)); end
      end
    end
  endtask

  task automatic test_pointer_wrap();
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] d;
    bit wr, rdy;
    int guard;
    guard = 0;
    got_q.delete(); got_cyc.delete();
    while (got_q.size() < 40 && guard < 3000) begin
      wr  = (sent_q.size() < 40) && (m_count < DEPTH) && ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 1) != 0);
      d   = $urandom;
      drive(wr, d, rdy);
      checks++; if (count !== CW'(m_count)) begin failures++; $display("FAIL wrap_count: got %0d expected %0d", count, m_count); end
      checks++; if (fifo_rd_en !== e_rd) begin failures++; $display("FAIL wrap_rd_en: got %b expected %b", fifo_rd_en, e_rd); end
      checks++; if (m_valid !== e_valid) begin failures++; $display("FAIL wrap_valid: got %b expected %b", m_valid, e_valid); end
      checks++; if (full !== (m_count == DEPTH) || empty !== (m_count == 0)) begin failures++; $display("FAIL wrap_flags: got full=%b empty=%b count_ref=%0d", full, empty, m_count); end
      if (e_valid) begin
        checks++; if (m_data !== e_data) begin failures++; $display("FAIL wrap_data: got %h expected %h", m_data, e_data); end
      end
      if (wr) sent_q.push_back(d);
      advance();
      guard++;
    end
    checks++; if (got_q.size() != 40) begin failures++; $display("FAIL wrap_words: got %0d expected 40", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
      checks++; if (got_q[i] !== sent_q[i]) begin failures++; $display("FAIL wrap_seq[%0d]: got %h expected %h", i, got_q[i], sent_q[i]); end
    end
    checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL wrap_ovf: got %b expected 0", ovf_err); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 3; i++) begin drive(1'b1, DW'(100 + i), 1'b0); advance(); end
    drive(1'b0, '0, 1'b0);
    checks++; if (count !== CW'(DEPTH) || full !== 1'b1) begin failures++; $display("FAIL ovf_count: got count=%0d full=%b expected %0d/1", count, full, DEPTH); end
    checks++; if (ovf_err !== (ERR_EN && m_ovf)) begin failures++; $display("FAIL ovf_set: got %b expected %b", ovf_err, ERR_EN && m_ovf); end
    advance();
    for (int i = 0; i < 3; i++) begin drive(1'b0, '0, 1'b0); advance(); end
    drive(1'b0, '0, 1'b0);
    checks++; if (ovf_err !== ERR_EN) begin failures++; $display("FAIL ovf_sticky: got %b expected %b", ovf_err, ERR_EN); end
    advance();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (ovf_err !== 1'b0 || count !== '0) begin failures++; $display("FAIL ovf_reset: got ovf=%b count=%0d expected 0/0", ovf_err, count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_pointer_wrap();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
